// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        BLANK,
        COMMIT
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [7:0] SQ_LOW  = 8'hA1;
    localparam logic [7:0] SQ_HIGH = 8'hDE;

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [3:0] an_select(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Loadable down-counter that times each scan slot; done while the count is zero.
module sseg_slot_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with shadow/active pattern banks.
// Define SSEG_DIM_EN to enable brightness-controlled anode duty within each ON slot.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [7:0] wr_pattern,
    input  logic [2:0] brightness,
    output logic [7:0] sseg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);

    state_t        state, next_state;
    logic [1:0]    digit, next_digit;
    logic          timer_load, timer_done, tick_next, accept, lit;
    logic [TW-1:0] timer_value, timer_count;
    logic [7:0]    shadow [4];
    logic [7:0]    active [4];
    logic          dirty;

    assign wr_ready = (state != COMMIT);
    assign accept   = wr_valid && wr_ready;

    sseg_slot_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .done       (timer_done)
    );

    // Next-state decode; the timer is reloaded on every state entry.
    always_comb begin
        next_state  = state;
        next_digit  = digit;
        timer_load  = 1'b0;
        timer_value = '0;
        tick_next   = 1'b0;
        if (!enable) begin
            next_state = IDLE;
            next_digit = 2'd0;
            timer_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    next_state  = ON;
                    next_digit  = 2'd0;
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end
                ON: if (timer_done) begin
                    next_state  = BLANK;
                    timer_load  = 1'b1;
                    timer_value = BLANK_LOAD;
                end
                BLANK: if (timer_done) begin
                    timer_load = 1'b1;
                    if (digit != 2'd3) begin
                        next_state  = ON;
                        next_digit  = digit + 2'd1;
                        timer_value = ON_LOAD;
                    end else begin
                        tick_next  = 1'b1;
                        next_digit = 2'd0;
                        // A write landing on this very cycle still joins the commit.
                        if (dirty || accept) begin
                            next_state = COMMIT;
                        end else begin
                            next_state  = ON;
                            timer_value = ON_LOAD;
                        end
                    end
                end
                COMMIT: begin
                    next_state  = ON;
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end
                default: begin
                    next_state = IDLE;
                    next_digit = 2'd0;
                    timer_load = 1'b1;
                end
            endcase
        end
    end

`ifdef SSEG_DIM_EN
    int next_elapsed;
    int lit_limit;

    // Duty is judged on the slot position the registered anode will show next.
    always_comb begin
        next_elapsed = 0;
        if (state == ON && next_state == ON)
            next_elapsed = ON_CYCLES - int'(timer_count);
        lit_limit = (int'(brightness) + 1) * (ON_CYCLES / 8);
        lit       = (next_elapsed < lit_limit);
    end
`else
    logic unused_dim_inputs;
    assign unused_dim_inputs = ^{brightness, timer_count};
    assign lit = 1'b1;
`endif

    // State, pattern banks and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            digit      <= 2'd0;
            dirty      <= 1'b0;
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= SEG_OFF;
                active[i] <= SEG_OFF;
            end
        end else begin
            state      <= next_state;
            digit      <= next_digit;
            frame_tick <= tick_next;
            if (accept) begin
                shadow[wr_digit] <= wr_pattern;
                dirty            <= 1'b1;
            end
            if (state == COMMIT && enable) begin
                active <= shadow;
                dirty  <= 1'b0;
            end
            if (next_state == ON) begin
                an   <= lit ? an_select(next_digit) : AN_OFF;
                sseg <= (state == COMMIT) ? shadow[next_digit] : active[next_digit];
            end else begin
                an   <= AN_OFF;
                sseg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with ON_CYCLES=8, BLANK_CYCLES=2 (frame = 40 cycles, +1 on commit).
module tb_sseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, enable, wr_valid, wr_ready, frame_tick;
    logic [1:0] wr_digit;
    logic [7:0] wr_pattern, sseg;
    logic [2:0] brightness;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.ON_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_digit   (wr_digit),
        .wr_pattern (wr_pattern),
        .brightness (brightness),
        .sseg       (sseg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected anode at position p of an uncommitted 40-cycle frame.
    function automatic logic [3:0] an_at(input int p);
        logic [3:0] one;
        one = 4'b0001;
        if ((p % 10) < 8) return ~(one << (p / 10));
        return 4'b1111;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; brightness = 3'd7;
        wr_valid = 1'b1; wr_digit = 2'd0; wr_pattern = 8'h00;
        tick(3);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL reset_sseg got %h want ff", sseg); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", frame_tick); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", wr_ready); end
        reset = 1'b0; enable = 1'b0; wr_valid = 1'b0;
        tick(2);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL idle_an got %b want 1111", an); end
    endtask

    // Leaves the bench at frame position 1 of the second frame.
    task automatic test_scan();
        enable = 1'b1;
        tick();
        for (int p = 0; p < 40; p++) begin
            checks++; if (an !== an_at(p)) begin errors++; $display("[TB] FAIL scan_an[%0d] got %b want %b", p, an, an_at(p)); end
            checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL scan_sseg[%0d] got %h want ff", p, sseg); end
            checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL scan_tick[%0d] got %b want 0", p, frame_tick); end
            tick();
        end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL frame_tick40 got %b want 1", frame_tick); end
        checks++; if (an !== 4'b1110) begin errors++; $display("[TB] FAIL wrap_an got %b want 1110", an); end
        tick();
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL tick_width got %b want 0", frame_tick); end
    endtask

    // Starts at p=1, leaves at p=20 of the frame after the commit.
    task automatic test_commit();
        wr_valid = 1'b1; wr_digit = 2'd2; wr_pattern = 8'hA1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        for (int p = 2; p < 40; p++) begin
            checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL no_tear[%0d] got %h want ff", p, sseg); end
            tick();
        end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL commit_tick got %b want 1", frame_tick); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL commit_ready got %b want 0", wr_ready); end
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL commit_an got %b want 1111", an); end
        tick();
        checks++; if (an !== 4'b1110) begin errors++; $display("[TB] FAIL post_commit_an got %b want 1110", an); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_commit_ready got %b want 1", wr_ready); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL post_commit_d0 got %h want ff", sseg); end
        tick(20);
        checks++; if (an !== 4'b1011) begin errors++; $display("[TB] FAIL d2_an got %b want 1011", an); end
        checks++; if (sseg !== 8'hA1) begin errors++; $display("[TB] FAIL d2_sseg got %h want a1", sseg); end
    endtask

    // Starts at p=20, leaves at p=20; also writes digit 0 on the BLANK(d=3) exit cycle.
    task automatic test_last_write();
        wr_valid = 1'b1; wr_digit = 2'd1; wr_pattern = 8'h11;
        tick();
        wr_pattern = 8'hDE;
        tick();
        wr_valid = 1'b0;
        tick(17);
        wr_valid = 1'b1; wr_digit = 2'd0; wr_pattern = 8'h11;
        tick();
        wr_valid = 1'b0;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL lw_commit_ready got %b want 0", wr_ready); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL lw_commit_tick got %b want 1", frame_tick); end
        tick();
        checks++; if (sseg !== 8'h11) begin errors++; $display("[TB] FAIL exit_write_d0 got %h want 11", sseg); end
        tick(10);
        checks++; if (an !== 4'b1101) begin errors++; $display("[TB] FAIL d1_an got %b want 1101", an); end
        checks++; if (sseg !== 8'hDE) begin errors++; $display("[TB] FAIL last_write_d1 got %h want de", sseg); end
        tick(10);
        checks++; if (sseg !== 8'hA1) begin errors++; $display("[TB] FAIL keep_d2 got %h want a1", sseg); end
    endtask

    // Starts at p=20 (digit 2 ON), leaves at p=30 of the frame after the next commit.
    task automatic test_disable();
        enable = 1'b0;
        tick();
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL dis_an got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL dis_sseg got %h want ff", sseg); end
        wr_valid = 1'b1; wr_digit = 2'd3; wr_pattern = 8'hDE;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL dis_ready got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        tick(2);
        checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL dis_hold_an got %b want 1111", an); end
        enable = 1'b1;
        tick();
        checks++; if (an !== 4'b1110) begin errors++; $display("[TB] FAIL restart_an got %b want 1110", an); end
        checks++; if (sseg !== 8'h11) begin errors++; $display("[TB] FAIL restart_d0 got %h want 11", sseg); end
        tick(10);
        checks++; if (sseg !== 8'hDE) begin errors++; $display("[TB] FAIL restart_d1 got %h want de", sseg); end
        tick(20);
        checks++; if (an !== 4'b0111) begin errors++; $display("[TB] FAIL restart_d3_an got %b want 0111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("[TB] FAIL idle_write_hidden got %h want ff", sseg); end
        tick(10);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL dirty_kept got %b want 0", wr_ready); end
        tick(31);
        checks++; if (sseg !== 8'hDE) begin errors++; $display("[TB] FAIL idle_write_d3 got %h want de", sseg); end
    endtask

    // Starts at p=30, leaves at p=0 of a fresh frame.
    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_digit = 2'd0; wr_pattern = 8'hA1;
        tick(10);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_commit_ready got %b want 0", wr_ready); end
        wr_pattern = 8'hDE;
        tick();
        checks++; if (sseg !== 8'hA1) begin errors++; $display("[TB] FAIL b2b_d0 got %h want a1", sseg); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++; if (sseg !== 8'hA1) begin errors++; $display("[TB] FAIL b2b_no_tear got %h want a1", sseg); end
        tick(39);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_recommit got %b want 0", wr_ready); end
        tick();
        checks++; if (sseg !== 8'hDE) begin errors++; $display("[TB] FAIL b2b_new_d0 got %h want de", sseg); end
    endtask

    task automatic test_brightness();
        int lit;
        int want_low;
        logic [3:0] an_p12;
`ifdef SSEG_DIM_EN
        want_low = 2;
`else
        want_low = 8;
`endif
        tick(9);
        brightness = 3'd1;
        lit = 0;
        an_p12 = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an !== 4'b1111) lit++;
            if (i == 2) an_p12 = an;
        end
        checks++; if (lit != want_low) begin errors++; $display("[TB] FAIL dim_low got %0d want %0d", lit, want_low); end
        checks++; if (an_p12 !== ((want_low == 2) ? 4'b1111 : 4'b1101)) begin errors++; $display("[TB] FAIL dim_low_p12 got %b", an_p12); end
        brightness = 3'd7;
        lit = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an !== 4'b1111) lit++;
        end
        checks++; if (lit != 8) begin errors++; $display("[TB] FAIL dim_full got %0d want 8", lit); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_last_write();
        test_disable();
        test_back_to_back();
        test_brightness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
